associate_trainer: RTL

Hardware sequencer that trains and checks one `associate` unit, replacing the bench-side training loop.
- Holds a small sample set of argument/target pairs.
- Per epoch, per sample: forward pass, linear threshold, error computation, backward pass.
- After EPOCHS epochs, runs one inference-only check pass and reports pass/fail plus mismatch count.
- Sits between a host/config port and the associate's arg/res/err/fbk valid-ready channels.

---
 rtl/associate_trainer_pkg.sv | 34 +++
 rtl/associate_sample_mem.sv | 24 ++
 rtl/associate_trainer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/associate_trainer_pkg.sv
// rtl/associate_trainer_pkg.sv - shared types, sizes and threshold helper for associate_trainer
package associate_trainer_pkg;

    localparam int          N      = 2;
    localparam int          W      = 8;
    localparam int          R      = 16;
    localparam int          DEPTH  = 4;
    localparam int          EPOCHS = 25;
    localparam logic [15:0] HIGH   = 16'h00ff;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int EW = $clog2(EPOCHS + 1);

    typedef enum logic [2:0] {
        IDLE,
        FWD_ARG,
        FWD_RES,
        BWD_ERR,
        BWD_FBK,
        CHK,
        FIN
    } state_t;

    typedef struct packed {
        logic [R-1:0]   tgt;
        logic [N*W-1:0] arg;
    } sample_t;

    function automatic logic [R-1:0] act(input logic [R-1:0] res);
        return res[R-1] ? '0 : HIGH;
    endfunction

endpackage

// File: rtl/associate_sample_mem.sv
// rtl/associate_sample_mem.sv - DEPTH-entry sample register file, one write port, async read
module associate_sample_mem
    import associate_trainer_pkg::*;
(
    input  logic          i_clock,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  sample_t       i_wdata,
    input  logic [IW-1:0] i_raddr,
    output sample_t       o_rdata
);

    // Contents deliberately survive reset; only the trainer's count is cleared.
    sample_t r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/associate_trainer.sv
// rtl/associate_trainer.sv - train/check sequencer for one associate unit; EARLY_STOP_EN ends training on a clean epoch
module associate_trainer
    import associate_trainer_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_smp_valid,
    output logic             o_smp_ready,
    input  logic [N*W+R-1:0] i_smp_data,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CW-1:0]    o_mismatches,
    output logic             o_train,
    output logic             o_arg_valid,
    input  logic             i_arg_ready,
    output logic [N*W-1:0]   o_arg_data,
    input  logic             i_res_valid,
    output logic             o_res_ready,
    input  logic [R-1:0]     i_res_data,
    output logic             o_err_valid,
    input  logic             i_err_ready,
    output logic [R-1:0]     o_err_data,
    input  logic             i_fbk_valid,
    output logic             o_fbk_ready,
    input  logic [N*R-1:0]   i_fbk_data
);

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_idx;
    logic [EW-1:0] r_epoch;
    logic [R-1:0]  r_err;
    logic [CW-1:0] r_chk_mis;
    logic [CW-1:0] r_mismatches;
    logic          r_pass;
    logic          r_done;
    logic          r_busy;
    logic          r_train;
    logic          r_all_zero;

    sample_t       w_rd;
    logic          w_smp_ready;
    logic          w_smp_we;
    logic [R-1:0]  w_err;
    logic          w_last;
    logic [EW-1:0] w_epoch_nxt;
    logic          w_end_train;
    logic          w_unused;

    assign w_smp_ready = (r_state == IDLE) && (r_count < CW'(DEPTH));
    assign w_smp_we    = i_reset && i_smp_valid && w_smp_ready;
    assign w_err       = w_rd.tgt - act(i_res_data);
    assign w_last      = (CW'(r_idx) + 1'b1) == r_count;
    assign w_epoch_nxt = r_epoch + 1'b1;
    assign w_unused    = ^i_fbk_data;

`ifdef EARLY_STOP_EN
    assign w_end_train = (w_epoch_nxt == EW'(EPOCHS)) || r_all_zero;
`else
    assign w_end_train = (w_epoch_nxt == EW'(EPOCHS));
`endif

    associate_sample_mem u_mem (
        .i_clock (i_clock),
        .i_we    (w_smp_we),
        .i_waddr (r_count[IW-1:0]),
        .i_wdata (sample_t'(i_smp_data)),
        .i_raddr (r_idx),
        .o_rdata (w_rd)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_idx        <= '0;
            r_epoch      <= '0;
            r_err        <= '0;
            r_chk_mis    <= '0;
            r_mismatches <= '0;
            r_pass       <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_train      <= 1'b0;
            r_all_zero   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_smp_we) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (i_start && (r_count != '0)) begin
                        r_state    <= FWD_ARG;
                        r_busy     <= 1'b1;
                        r_train    <= 1'b1;
                        r_epoch    <= '0;
                        r_idx      <= '0;
                        r_all_zero <= 1'b1;
                    end
                end
                FWD_ARG: begin
                    if (i_arg_ready) begin
                        r_state <= FWD_RES;
                    end
                end
                FWD_RES: begin
                    if (i_res_valid) begin
                        r_err   <= w_err;
                        r_state <= r_train ? BWD_ERR : CHK;
                        if (w_err != '0) begin
                            r_all_zero <= 1'b0;
                        end
                    end
                end
                BWD_ERR: begin
                    if (i_err_ready) begin
                        r_state <= BWD_FBK;
                    end
                end
                BWD_FBK: begin
                    if (i_fbk_valid) begin
                        r_state <= FWD_ARG;
                        if (w_last) begin
                            // Epoch boundary: the only point where train may drop mid-run.
                            r_idx      <= '0;
                            r_epoch    <= w_epoch_nxt;
                            r_all_zero <= 1'b1;
                            if (w_end_train) begin
                                r_train   <= 1'b0;
                                r_chk_mis <= '0;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                CHK: begin
                    if ((r_err != '0) && (r_chk_mis != CW'(DEPTH))) begin
                        r_chk_mis <= r_chk_mis + 1'b1;
                    end
                    if (w_last) begin
                        r_state <= FIN;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= FWD_ARG;
                    end
                end
                FIN: begin
                    r_pass       <= (r_chk_mis == '0);
                    r_mismatches <= r_chk_mis;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_train      <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_smp_ready  = w_smp_ready;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_mismatches = r_mismatches;
    assign o_train      = r_train;
    assign o_arg_valid  = (r_state == FWD_ARG);
    assign o_arg_data   = w_rd.arg;
    assign o_res_ready  = (r_state == FWD_RES);
    assign o_err_valid  = (r_state == BWD_ERR);
    assign o_err_data   = r_err;
    assign o_fbk_ready  = (r_state == BWD_FBK);

endmodule
